// File: rtl/ip_fp_pkg.sv
// Shared types and constants for the packed-float datapath: format defaults, rounding modes,
// status bit positions and the float-to-int converter state encoding.
package ip_fp_pkg;

    localparam int unsigned DEF_EXP  = 5;
    localparam int unsigned DEF_FRAC = 10;
    localparam int unsigned DEF_BIAS = 15;
    localparam int unsigned DEF_INT  = 16;

    localparam logic [2:0] RND_RNE = 3'd0;
    localparam logic [2:0] RND_RTZ = 3'd1;
    localparam logic [2:0] RND_RUP = 3'd2;
    localparam logic [2:0] RND_RDN = 3'd3;

    localparam int unsigned ST_INVALID  = 0;
    localparam int unsigned ST_OVERFLOW = 1;
    localparam int unsigned ST_INEXACT  = 2;
    localparam int unsigned ST_ZERO     = 3;

    typedef enum logic [1:0] {StIdle, StShift, StRound, StOut} state_e;

    // Increment decision on a magnitude; unlisted encodings fall back to RND_RNE.
    function automatic logic round_up(input logic [2:0] mode, input logic sign, input logic g,
                                      input logic r, input logic lsb);
        case (mode)
            RND_RTZ: return 1'b0;
            RND_RUP: return (g | r) & ~sign;
            RND_RDN: return (g | r) & sign;
            default: return g & (r | lsb);
        endcase
    endfunction

endpackage

// File: rtl/ip_fp_unpack.sv
// Combinational split of a packed float into sign/fraction, class flags and unbiased exponent.
module ip_fp_unpack
    import ip_fp_pkg::*;
#(
    parameter int unsigned P_EXP  = DEF_EXP,
    parameter int unsigned P_FRAC = DEF_FRAC,
    parameter int unsigned P_BIAS = DEF_BIAS,
    parameter int unsigned P_WORD = 1 + P_EXP + P_FRAC
) (
    input  logic [P_WORD-1:0]       word_i,
    output logic                    sign_o,
    output logic [P_FRAC-1:0]       frac_o,
    output logic                    is_nan_o,
    output logic                    is_inf_o,
    output logic                    is_zero_o,
    output logic                    is_denorm_o,
    output logic signed [P_EXP+1:0] unb_exp_o
);
    logic [P_EXP-1:0] exp_f;

    assign sign_o      = word_i[P_WORD-1];
    assign exp_f       = word_i[P_FRAC +: P_EXP];
    assign frac_o      = word_i[P_FRAC-1:0];
    assign is_nan_o    = (&exp_f) & (|frac_o);
    assign is_inf_o    = (&exp_f) & ~(|frac_o);
    assign is_zero_o   = ~(|exp_f) & ~(|frac_o);
    assign is_denorm_o = ~(|exp_f) & (|frac_o);
    assign unb_exp_o   = $signed({2'b00, exp_f}) - $signed((P_EXP+2)'(P_BIAS));

endmodule

// File: rtl/ip_fp_to_int.sv
// Sequential float-to-signed-integer converter: one-bit-per-cycle alignment, then round,
// saturate and report status on a valid/ready stream.
module ip_fp_to_int
    import ip_fp_pkg::*;
#(
    parameter int unsigned P_EXP  = DEF_EXP,
    parameter int unsigned P_FRAC = DEF_FRAC,
    parameter int unsigned P_BIAS = DEF_BIAS,
    parameter int unsigned P_WORD = 1 + P_EXP + P_FRAC,
    parameter int unsigned P_INT  = DEF_INT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [P_WORD-1:0] in_data,
    input  logic [2:0]        rnd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P_INT-1:0]  out_int,
    output logic [7:0]        out_status
);
    localparam int unsigned AccW = P_INT + P_FRAC + 2;
    localparam int unsigned CntW = $clog2(P_INT + 1);
    localparam logic [P_INT-1:0] IntMax    = {1'b0, {(P_INT-1){1'b1}}};
    localparam logic [P_INT-1:0] IntMin    = {1'b1, {(P_INT-1){1'b0}}};
    localparam logic [P_INT:0]   MagMaxPos = {2'b00, {(P_INT-1){1'b1}}};
    localparam logic [P_INT:0]   MagMaxNeg = {2'b01, {(P_INT-1){1'b0}}};

    logic                    sign, is_nan, is_inf, is_zero, is_denorm;
    logic [P_FRAC-1:0]       frac;
    logic signed [P_EXP+1:0] unb_exp;
    int                      k;

    ip_fp_unpack #(
        .P_EXP  (P_EXP),
        .P_FRAC (P_FRAC),
        .P_BIAS (P_BIAS),
        .P_WORD (P_WORD)
    ) u_unpack (
        .word_i      (in_data),
        .sign_o      (sign),
        .frac_o      (frac),
        .is_nan_o    (is_nan),
        .is_inf_o    (is_inf),
        .is_zero_o   (is_zero),
        .is_denorm_o (is_denorm),
        .unb_exp_o   (unb_exp)
    );

    assign k = int'(unb_exp);

    state_e            state_q, state_d;
    logic              sign_q, sign_d;
    logic [2:0]        rnd_q, rnd_d;
    logic              right_q, right_d;
    logic              sticky_q, sticky_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [P_INT-1:0]  out_int_q, out_int_d;
    logic [7:0]        out_status_q, out_status_d;

    logic              g, r, up, ovf, tiny_nz;
    logic [P_INT:0]    int_f, mag;
    logic [P_INT-1:0]  rnd_res, tiny_res;

    // Rounding of the aligned accumulator {integer field, fraction field}.
    always_comb begin
        int_f   = acc_q[AccW-1 -: P_INT+1];
        g       = acc_q[P_FRAC];
        r       = (|acc_q[P_FRAC-1:0]) | sticky_q;
        up      = round_up(rnd_q, sign_q, g, r, int_f[0]);
        mag     = int_f + {{P_INT{1'b0}}, up};
        ovf     = sign_q ? (mag > MagMaxNeg) : (mag > MagMaxPos);
        rnd_res = sign_q ? (~mag[P_INT-1:0] + {{(P_INT-1){1'b0}}, 1'b1}) : mag[P_INT-1:0];
    end

    // Magnitudes below one half only move away from zero under a directed mode.
    always_comb begin
        tiny_nz = ~is_zero;
        if (tiny_nz && rnd == RND_RUP && !sign) begin
            tiny_res = {{(P_INT-1){1'b0}}, 1'b1};
        end else if (tiny_nz && rnd == RND_RDN && sign) begin
            tiny_res = '1;
        end else begin
            tiny_res = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        sign_d       = sign_q;
        rnd_d        = rnd_q;
        right_d      = right_q;
        sticky_d     = sticky_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        out_int_d    = out_int_q;
        out_status_d = out_status_q;
        in_ready     = (state_q == StIdle);
        out_valid    = (state_q == StOut);

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d       = sign;
                    rnd_d        = rnd;
                    sticky_d     = 1'b0;
                    right_d      = (k == -1);
                    out_status_d = '0;
                    state_d      = StOut;
                    if (is_nan) begin
                        out_int_d                = IntMax;
                        out_status_d[ST_INVALID] = 1'b1;
                    end else if (is_inf) begin
                        out_int_d                = sign ? IntMin : IntMax;
                        out_status_d[ST_INVALID] = 1'b1;
                    end else if (is_zero || is_denorm || k < -1) begin
                        out_int_d                = tiny_res;
                        out_status_d[ST_INEXACT] = tiny_nz;
                        out_status_d[ST_ZERO]    = (tiny_res == '0);
                    end else if (k >= int'(P_INT)) begin
                        out_int_d                 = sign ? IntMin : IntMax;
                        out_status_d[ST_OVERFLOW] = 1'b1;
                    end else begin
                        acc_d   = {{P_INT{1'b0}}, 1'b1, frac, 1'b0};
                        cnt_d   = (k < 0) ? CntW'(1) : CntW'(k);
                        state_d = (k == 0) ? StRound : StShift;
                    end
                end
            end
            StShift: begin
                acc_d    = right_q ? (acc_q >> 1) : (acc_q << 1);
                sticky_d = sticky_q | (right_q & acc_q[0]);
                cnt_d    = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                out_status_d = '0;
                if (ovf) begin
                    out_int_d                 = sign_q ? IntMin : IntMax;
                    out_status_d[ST_OVERFLOW] = 1'b1;
                end else begin
                    out_int_d                = rnd_res;
                    out_status_d[ST_INEXACT] = g | r;
                    out_status_d[ST_ZERO]    = (rnd_res == '0);
                end
                state_d = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            sign_q       <= 1'b0;
            rnd_q        <= '0;
            right_q      <= 1'b0;
            sticky_q     <= 1'b0;
            cnt_q        <= '0;
            acc_q        <= '0;
            out_int_q    <= '0;
            out_status_q <= '0;
        end else begin
            state_q      <= state_d;
            sign_q       <= sign_d;
            rnd_q        <= rnd_d;
            right_q      <= right_d;
            sticky_q     <= sticky_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            out_int_q    <= out_int_d;
            out_status_q <= out_status_d;
        end
    end

    assign out_int    = out_int_q;
    assign out_status = out_status_q;

endmodule

// File: tb/tb_ip_fp_to_int.sv
// Bench for ip_fp_to_int: directed cases, backpressure, mid-conversion reset and random
// words checked against a real-arithmetic reference.
module tb_ip_fp_to_int;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [2:0]  rnd;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_int;
    logic [7:0]  out_status;

    int tests;
    int fails;

    ip_fp_to_int dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .rnd        (rnd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_int    (out_int),
        .out_status (out_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference: exact value as a real, rounded by mode, then range-checked.
    function automatic void model(input logic [15:0] w, input logic [2:0] rm,
                                  output logic [15:0] ri, output logic [7:0] rs,
                                  output int lat);
        int  e, f, k, sh, fi;
        bit  s;
        real v, fl, dif, rv;
        s  = w[15];
        e  = int'(w[14:10]);
        f  = int'(w[9:0]);
        k  = e - 15;
        rs = 8'h00;
        if (e == 31) begin
            ri  = (f != 0 || !s) ? 16'h7FFF : 16'h8000;
            rs  = 8'h01;
            lat = 1;
            return;
        end
        lat = (e == 0 || k < -1 || k >= 16) ? 1 : 2 + ((k < 0) ? -k : k);
        v   = (e == 0) ? real'(f) : real'(1024 + f);
        sh  = ((e == 0) ? 1 : e) - 25;
        for (int i = 0; i < sh; i++) v = v * 2.0;
        for (int i = 0; i < -sh; i++) v = v / 2.0;
        if (s) v = -v;
        fl  = $floor(v);
        dif = v - fl;
        case (rm)
            3'd1: rv = s ? $ceil(v) : fl;
            3'd2: rv = $ceil(v);
            3'd3: rv = fl;
            default: begin
                fi = $rtoi(fl);
                if (dif > 0.5) rv = fl + 1.0;
                else if (dif < 0.5) rv = fl;
                else rv = ((fi % 2) == 0) ? fl : fl + 1.0;
            end
        endcase
        if (rv > 32767.0 || rv < -32768.0) begin
            ri = s ? 16'h8000 : 16'h7FFF;
            rs = 8'h02;
        end else begin
            ri    = 16'($rtoi(rv));
            rs[2] = (rv != v);
            rs[3] = (ri == 16'h0000);
        end
    endfunction

    task automatic run_one(input string tag, input logic [15:0] w, input logic [2:0] rm,
                           input logic [15:0] ei, input logic [7:0] es, input int el,
                           input int hold);
        int lat;
        in_data  = w;
        rnd      = rm;
        in_valid = 1'b1;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 16'h3E00;
        lat      = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " out_int"}, 32'(out_int), 32'(ei));
        check({tag, " out_status"}, 32'(out_status), 32'(es));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            tick();
            check({tag, " held valid"}, 32'(out_valid), 32'd1);
            check({tag, " held int"}, 32'(out_int), 32'(ei));
            check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " ready back"}, 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    logic [31:0] rw;
    logic [15:0] w, ei;
    logic [7:0]  es;
    logic [2:0]  rm;
    int          el;
    int          stale;

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        rnd       = '0;
        repeat (2) tick();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_int", 32'(out_int), 32'd0);
        check("reset out_status", 32'(out_status), 32'd0);
        rst_n = 1'b1;
        tick();
        check("reset in_ready", 32'(in_ready), 32'd1);

        run_one("pi rne",     16'h4248, 3'd0, 16'h0003, 8'h04, 3, 0);
        run_one("-2.5 rne",   16'hC100, 3'd0, 16'hFFFE, 8'h04, 3, 0);
        run_one("-2.5 rtz",   16'hC100, 3'd1, 16'hFFFE, 8'h04, 3, 0);
        run_one("-2.5 rdn",   16'hC100, 3'd3, 16'hFFFD, 8'h04, 3, 0);
        run_one("-2.5 rup",   16'hC100, 3'd2, 16'hFFFE, 8'h04, 3, 0);
        run_one("1.5 rne",    16'h3E00, 3'd0, 16'h0002, 8'h04, 2, 0);
        run_one("0.5 rne",    16'h3800, 3'd0, 16'h0000, 8'h0C, 3, 0);
        run_one("65504",      16'h7BFF, 3'd0, 16'h7FFF, 8'h02, 17, 0);
        run_one("-32768",     16'hF800, 3'd0, 16'h8000, 8'h00, 17, 0);
        run_one("nan",        16'h7E00, 3'd0, 16'h7FFF, 8'h01, 1, 0);
        run_one("-inf",       16'hFC00, 3'd0, 16'h8000, 8'h01, 1, 0);
        run_one("-0",         16'h8000, 3'd0, 16'h0000, 8'h08, 1, 0);
        run_one("denorm rup", 16'h0001, 3'd2, 16'h0001, 8'h04, 1, 0);
        run_one("-denorm rdn",16'h8001, 3'd3, 16'hFFFF, 8'h04, 1, 0);
        run_one("0.25 rup",   16'h3400, 3'd2, 16'h0001, 8'h04, 1, 0);
        run_one("-0.25 rup",  16'hB400, 3'd2, 16'h0000, 8'h0C, 1, 0);

        // Backpressure with a pending input; the pending word is taken only afterwards.
        run_one("backpressure", 16'h4248, 3'd0, 16'h0003, 8'h04, 3, 5);
        run_one("after bp",     16'h3E00, 3'd0, 16'h0002, 8'h04, 2, 0);

        // Reset in the middle of a long shift.
        in_data  = 16'hF800;
        rnd      = 3'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst out_int", 32'(out_int), 32'd0);
        check("midrst out_status", 32'(out_status), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (out_valid) stale++;
        end
        check("midrst stale result", 32'(stale), 32'd0);
        run_one("post reset", 16'hF800, 3'd0, 16'h8000, 8'h00, 17, 0);

        for (int n = 0; n < 150; n++) begin
            rw = $urandom();
            w  = rw[15:0];
            rm = 3'($urandom_range(0, 7));
            model(w, rm, ei, es, el);
            run_one("random", w, rm, ei, es, el, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
